// File: rtl/systolic_feeder_if.sv
// systolic_feeder_if: operand load, sequence control and skewed PE stream bundle
interface systolic_feeder_if #(
    parameter int N = 2,
    parameter int WIDTH = 8
);
    localparam int AW = $clog2(N * N);
    logic                    load_en;
    logic                    load_sel;
    logic [AW-1:0]           load_addr;
    logic signed [WIDTH-1:0] load_data;
    logic                    start;
    logic                    busy;
    logic                    done;
    logic                    clear_out;
    logic                    a_valid;
    logic [N*WIDTH-1:0]      a_data;
    logic [N*WIDTH-1:0]      b_data;
    modport master (
        output load_en, load_sel, load_addr, load_data, start,
        input  busy, done, clear_out, a_valid, a_data, b_data
    );
    modport slave (
        input  load_en, load_sel, load_addr, load_data, start,
        output busy, done, clear_out, a_valid, a_data, b_data
    );
endinterface

// File: rtl/systolic_feeder.sv
// systolic_feeder: holds an NxN operand pair and streams skewed rows/cols into a PE grid
module systolic_feeder #(
    parameter int N = 2,
    parameter int WIDTH = 8
) (
    input logic clk,
    input logic rst,
    systolic_feeder_if.slave bus
);
    localparam int AW = $clog2(N * N);
    localparam int CW = $clog2(2 * N);
    localparam logic [AW:0] CELLS = (AW + 1)'(N * N);
    typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;
    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [N*N-1:0][WIDTH-1:0] a_mem, b_mem;
    logic [N-1:0][WIDTH-1:0] a_n, b_n;
    logic wr_ok;
    assign wr_ok = bus.load_en && (state == IDLE || state == DONE) && {1'b0, bus.load_addr} < CELLS;
    assign state_n = state == IDLE  ? (bus.start ? CLEAR : IDLE) :
                     state == CLEAR ? FEED :
                     state == FEED  ? (cnt == CW'(2 * N - 2) ? DRAIN : FEED) :
                     state == DRAIN ? (cnt == CW'(N - 2) ? DONE : DRAIN) : IDLE;
    assign cnt_n = (state_n == state && state != IDLE) ? cnt + 1'b1 : '0;
    // Outputs are registered from next-state values, so slice t uses the step it is entering.
    always_comb begin
        a_n = '0;
        b_n = '0;
        if (state_n == FEED)
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    if (int'(cnt_n) == i + j) begin
                        a_n[i] = a_mem[i*N+j];
                        b_n[j] = b_mem[i*N+j];
                    end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            a_mem         <= '0;
            b_mem         <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.clear_out <= 1'b0;
            bus.a_valid   <= 1'b0;
            bus.a_data    <= '0;
            bus.b_data    <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (wr_ok && !bus.load_sel) a_mem[bus.load_addr] <= bus.load_data;
            if (wr_ok && bus.load_sel) b_mem[bus.load_addr] <= bus.load_data;
            bus.busy      <= state_n inside {CLEAR, FEED, DRAIN};
            bus.done      <= state_n == DONE;
            bus.clear_out <= state_n == CLEAR;
            bus.a_valid   <= state_n == FEED;
            bus.a_data    <= a_n;
            bus.b_data    <= b_n;
        end
    end
endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: directed scenarios for the feeder driving a behavioural 2x2 PE grid
module tb_systolic_feeder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    systolic_feeder_if #(.N(2), .WIDTH(8)) bus ();
    systolic_feeder #(.N(2), .WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;
    logic [15:0] ad[3], bd[3];
    logic [2:0] av;
    logic clr0, busy0, busy4, done_after;
    int done_at;
    int cc[2][2];

    // Reference 2x2 output-stationary PE grid: a moves east, b moves south.
    logic signed [7:0] pa[2][2], pb[2][2];
    int acc[2][2];
    function automatic logic signed [7:0] ain(int i, int j);
        return j == 0 ? $signed(bus.a_data[i*8 +: 8]) : pa[i][j-1];
    endfunction
    function automatic logic signed [7:0] bin(int i, int j);
        return i == 0 ? $signed(bus.b_data[j*8 +: 8]) : pb[i-1][j];
    endfunction
    always @(posedge clk)
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                if (rst || bus.clear_out) begin
                    acc[i][j] <= 0;
                    pa[i][j]  <= '0;
                    pb[i][j]  <= '0;
                end else begin
                    acc[i][j] <= acc[i][j] + int'(ain(i, j)) * int'(bin(i, j));
                    pa[i][j]  <= ain(i, j);
                    pb[i][j]  <= bin(i, j);
                end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic sel, input logic [1:0] addr, input logic signed [7:0] d);
        bus.load_en = 1'b1;
        bus.load_sel = sel;
        bus.load_addr = addr;
        bus.load_data = d;
        tick;
        bus.load_en = 1'b0;
    endtask

    task automatic load_s1;
        for (int k = 0; k < 4; k++) load(1'b0, 2'(k), 8'(k + 1));
        for (int k = 0; k < 4; k++) load(1'b1, 2'(k), 8'(k + 5));
    endtask

    // Runs one sequence and records what appeared; poke writes A[0][0]=9 during FEED.
    task automatic run_seq(input bit poke);
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        bus.load_en = 1'b0;
        clr0 = bus.clear_out;
        busy0 = bus.busy;
        for (int t = 0; t < 3; t++) begin
            if (poke && t > 0) begin
                bus.load_en = 1'b1;
                bus.load_sel = 1'b0;
                bus.load_addr = 2'd0;
                bus.load_data = 8'sd9;
            end
            tick;
            av[t] = bus.a_valid;
            ad[t] = bus.a_data;
            bd[t] = bus.b_data;
        end
        bus.load_en = 1'b0;
        done_at = -1;
        for (int k = 4; k <= 12 && done_at < 0; k++) begin
            tick;
            if (k == 4) busy4 = bus.busy;
            if (bus.done) begin
                done_at = k;
                cc = acc;
            end
        end
        tick;
        done_after = bus.done;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick;
        tick;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", bus.done); end
        checks++; if (bus.clear_out !== 1'b0) begin errors++; $display("FAIL reset_clear got %b exp 0", bus.clear_out); end
        checks++; if (bus.a_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.a_valid); end
        checks++; if (bus.a_data !== 16'h0) begin errors++; $display("FAIL reset_a got %h exp 0000", bus.a_data); end
        checks++; if (bus.b_data !== 16'h0) begin errors++; $display("FAIL reset_b got %h exp 0000", bus.b_data); end
        rst = 1'b0;
        tick;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b exp 0", bus.busy); end
    endtask

    task automatic test_basic;
        logic [15:0] ea[3] = '{16'h0001, 16'h0302, 16'h0400};
        logic [15:0] eb[3] = '{16'h0005, 16'h0607, 16'h0800};
        int ec[2][2] = '{'{19, 22}, '{43, 50}};
        load_s1;
        run_seq(1'b0);
        checks++; if (clr0 !== 1'b1) begin errors++; $display("FAIL basic_clear got %b exp 1", clr0); end
        checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL basic_busy_clear got %b exp 1", busy0); end
        checks++; if (av !== 3'b111) begin errors++; $display("FAIL basic_valid got %b exp 111", av); end
        for (int t = 0; t < 3; t++) begin
            checks++; if (ad[t] !== ea[t]) begin errors++; $display("FAIL basic_a%0d got %h exp %h", t, ad[t], ea[t]); end
            checks++; if (bd[t] !== eb[t]) begin errors++; $display("FAIL basic_b%0d got %h exp %h", t, bd[t], eb[t]); end
        end
        checks++; if (busy4 !== 1'b1) begin errors++; $display("FAIL basic_busy_drain got %b exp 1", busy4); end
        checks++; if (done_at !== 5) begin errors++; $display("FAIL basic_done_edge got %0d exp 5", done_at); end
        checks++; if (done_after !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b exp 0", done_after); end
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                checks++; if (cc[i][j] !== ec[i][j]) begin errors++; $display("FAIL basic_c%0d%0d got %0d exp %0d", i, j, cc[i][j], ec[i][j]); end
            end
    endtask

    task automatic test_extremes;
        logic [15:0] ea[3] = '{16'h0080, 16'h8080, 16'h8000};
        logic [15:0] eb[3] = '{16'h007F, 16'h7F7F, 16'h7F00};
        for (int k = 0; k < 4; k++) load(1'b0, 2'(k), -8'sd128);
        for (int k = 0; k < 4; k++) load(1'b1, 2'(k), 8'sd127);
        run_seq(1'b0);
        for (int t = 0; t < 3; t++) begin
            checks++; if (ad[t] !== ea[t]) begin errors++; $display("FAIL ext_a%0d got %h exp %h", t, ad[t], ea[t]); end
            checks++; if (bd[t] !== eb[t]) begin errors++; $display("FAIL ext_b%0d got %h exp %h", t, bd[t], eb[t]); end
        end
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                checks++; if (cc[i][j] !== -32512) begin errors++; $display("FAIL ext_c%0d%0d got %0d exp -32512", i, j, cc[i][j]); end
            end
    endtask

    task automatic test_start_held;
        int clears = 0;
        int dones = 0;
        load_s1;
        bus.start = 1'b1;
        for (int k = 0; k < 14; k++) begin
            if (k == 7) bus.start = 1'b0;
            tick;
            clears += int'(bus.clear_out);
            dones += int'(bus.done);
        end
        checks++; if (clears !== 1) begin errors++; $display("FAIL held_clears got %0d exp 1", clears); end
        checks++; if (dones !== 1) begin errors++; $display("FAIL held_dones got %0d exp 1", dones); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL held_idle_busy got %b exp 0", bus.busy); end
        run_seq(1'b0);
        checks++; if (done_at !== 5) begin errors++; $display("FAIL held_second_done got %0d exp 5", done_at); end
        checks++; if (cc[0][0] !== 19) begin errors++; $display("FAIL held_second_c00 got %0d exp 19", cc[0][0]); end
    endtask

    task automatic test_load_during_feed;
        logic [15:0] ea[3] = '{16'h0001, 16'h0302, 16'h0400};
        run_seq(1'b1);
        checks++; if (ad[0] !== 16'h0001) begin errors++; $display("FAIL poke_a0 got %h exp 0001", ad[0]); end
        run_seq(1'b0);
        for (int t = 0; t < 3; t++) begin
            checks++; if (ad[t] !== ea[t]) begin errors++; $display("FAIL rerun_a%0d got %h exp %h", t, ad[t], ea[t]); end
        end
        checks++; if (cc[0][0] !== 19) begin errors++; $display("FAIL rerun_c00 got %0d exp 19", cc[0][0]); end
    endtask

    task automatic test_load_with_start;
        bus.load_en = 1'b1;
        bus.load_sel = 1'b0;
        bus.load_addr = 2'd3;
        bus.load_data = -8'sd5;
        run_seq(1'b0);
        checks++; if (ad[1] !== 16'h0302) begin errors++; $display("FAIL ldst_a1 got %h exp 0302", ad[1]); end
        checks++; if (ad[2] !== 16'hFB00) begin errors++; $display("FAIL ldst_a2 got %h exp fb00", ad[2]); end
        checks++; if (cc[1][1] !== -22) begin errors++; $display("FAIL ldst_c11 got %0d exp -22", cc[1][1]); end
    endtask

    task automatic test_reset_mid;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        tick;
        tick;
        checks++; if (bus.a_valid !== 1'b1) begin errors++; $display("FAIL mid_slice1_valid got %b exp 1", bus.a_valid); end
        rst = 1'b1;
        tick;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b exp 0", bus.busy); end
        checks++; if (bus.a_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b exp 0", bus.a_valid); end
        checks++; if ({bus.a_data, bus.b_data} !== 32'h0) begin errors++; $display("FAIL mid_data got %h exp 0", {bus.a_data, bus.b_data}); end
        checks++; if ({bus.done, bus.clear_out} !== 2'b00) begin errors++; $display("FAIL mid_ctrl got %b exp 00", {bus.done, bus.clear_out}); end
        rst = 1'b0;
        tick;
        run_seq(1'b0);
        checks++; if (av !== 3'b111) begin errors++; $display("FAIL zero_valid got %b exp 111", av); end
        for (int t = 0; t < 3; t++) begin
            checks++; if ({ad[t], bd[t]} !== 32'h0) begin errors++; $display("FAIL zero_slice%0d got %h exp 0", t, {ad[t], bd[t]}); end
        end
        checks++; if (done_at !== 5) begin errors++; $display("FAIL zero_done got %0d exp 5", done_at); end
        checks++; if (cc[1][1] !== 0) begin errors++; $display("FAIL zero_c11 got %0d exp 0", cc[1][1]); end
    endtask

    initial begin
        bus.load_en = 1'b0;
        bus.load_sel = 1'b0;
        bus.load_addr = '0;
        bus.load_data = '0;
        bus.start = 1'b0;
        test_reset;
        test_basic;
        test_extremes;
        test_start_held;
        test_load_during_feed;
        test_load_with_start;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
